imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter EN_ZIMM, default 1, enables CSR zimm decode; when 0, CSR immediates decode as fmt NONE.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  upstream entry valid.
REQ-007 in_ready  output  1  block can accept an entry this cycle.
REQ-008 in_instr  input  32  instruction word.
REQ-009 in_pc  input  XLEN  instruction address.
REQ-010 out_valid  output  1  output entry valid.
REQ-011 out_ready  input  1  downstream accepts the entry.
REQ-012 out_imm  output  XLEN  decoded immediate.
REQ-013 out_fmt  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
REQ-014 out_target  output  XLEN  in_pc + out_imm, modulo 2^XLEN.
REQ-015 out_illegal  output  1  opcode/encoding unsupported at this XLEN.

Function
REQ-016 Transfer occurs on a rising edge with valid and ready both high; out_* SHALL be stable while out_valid=1 and out_ready=0.
REQ-017 Latency SHALL be exactly one cycle from input transfer to out_valid, with back-to-back throughput of one entry per cycle while out_ready=1.
REQ-018 Storage SHALL be a 2-entry skid buffer (output register + skid register); in_ready SHALL equal NOT skid_valid, driven from a register, with no combinational path from out_ready.
REQ-019 Output order SHALL equal input order; stalled entry moves to output register when out_ready returns.
REQ-020 Opcodes 0010011, 0000011, 1100111 SHALL give fmt I, imm = sign-extended instr[31:20].
REQ-021 Opcode 0010011 with funct3 001 or 101 SHALL give fmt SHAMT, imm = zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64); XLEN=32 with instr[25]=1 SHALL set out_illegal.
REQ-022 Opcode 0100011 SHALL give fmt S, imm = sign-extended {instr[31:25], instr[11:7]}.
REQ-023 Opcode 1100011 SHALL give fmt B, imm = sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
REQ-024 Opcodes 0110111, 0010111 SHALL give fmt U, imm = {instr[31:12], 12 zeros} sign-extended from bit 31 to XLEN.
REQ-025 Opcode 1101111 SHALL give fmt J, imm = sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-026 Opcode 1110011 with funct3[2]=1 and EN_ZIMM=1 SHALL give fmt ZIMM, imm = zero-extended instr[19:15].
REQ-027 Opcode 0011011 SHALL decode as REQ-020/021 (SHAMT 5 bits, instr[25]=1 illegal) when XLEN=64 and SHALL set out_illegal when XLEN=32.
REQ-028 Opcodes 0110011, 0111011 (XLEN=64 only), 0001111, and 1110011 otherwise SHALL give fmt NONE, imm 0, out_illegal 0; every other opcode SHALL give fmt NONE, imm 0, out_illegal 1.
REQ-029 flush SHALL clear both entries at the edge it is sampled; an input transfer in the same cycle SHALL be discarded; in_ready SHALL be 1 the cycle after.

Reset
REQ-030 rst_n low SHALL immediately force out_valid=0, skid_valid=0, in_ready=1; out_imm, out_target, out_fmt, out_illegal SHALL reset to 0.
REQ-031 Reset asserted mid-stall SHALL drop all buffered entries without an out_valid pulse.

Structure
REQ-032 Package imm_gen_pkg SHALL hold the fmt enumeration and opcode constants.
REQ-033 Combinational decode SHALL be a sub-module imm_decode (instr in; imm, fmt, illegal out), instantiated once at the buffer input.

Verification
REQ-034 XLEN=32, instr 0xFFF00093 (addi imm -1), pc 0x100, out_ready=1 -> next cycle out_imm 0xFFFFFFFF, fmt I, target 0x000000FF.
REQ-035 XLEN=64, instr 0x800000B7 (lui) -> out_imm 0xFFFFFFFF80000000, fmt U.
REQ-036 B-type 0xFE000EE3 (imm -4), pc 0x1000 -> out_imm 0xFFFFFFFC, target 0x00000FFC, fmt B.
REQ-037 Three back-to-back entries, out_ready low 2 cycles after the first -> in_ready drops after 2nd accepted, all 3 emerge in order, none lost or duplicated.
REQ-038 XLEN=32 slli with instr[25]=1 (0x02009093) -> out_illegal 1, fmt SHAMT; opcode 0x7F -> illegal 1, fmt NONE.
REQ-039 Two entries buffered, flush=1 with in_valid=1 -> out_valid 0 next cycle, in_ready 1, flushed input never appears.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared immediate-format encoding and RISC-V major opcode constants
// for the immediate generator pipeline.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Purely combinational immediate decoder: extracts and extends the immediate,
// classifies its format and flags encodings that are not legal at this XLEN.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int EN_ZIMM = 1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3[1:0] == 2'b01);

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (is_shift) begin
          fmt = FMT_SHAMT;
          if (XLEN == 64) begin
            imm = XLEN'(instr[25:20]);
          end else begin
            imm     = XLEN'(instr[24:20]);
            illegal = instr[25];
          end
        end else begin
          fmt = FMT_I;
          imm = XLEN'($signed(instr[31:20]));
        end
      end
      // Word ops only exist on RV64; their shift amount is always 5 bits.
      OP_IMM32: begin
        if (XLEN == 32) begin
          illegal = 1'b1;
        end else if (is_shift) begin
          fmt     = FMT_SHAMT;
          imm     = XLEN'(instr[24:20]);
          illegal = instr[25];
        end else begin
          fmt = FMT_I;
          imm = XLEN'($signed(instr[31:20]));
        end
      end
      OP_LOAD, OP_JALR: begin
        fmt = FMT_I;
        imm = XLEN'($signed(instr[31:20]));
      end
      OP_STORE: begin
        fmt = FMT_S;
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        fmt = FMT_U;
        imm = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OP_JAL: begin
        fmt = FMT_J;
        imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      OP_SYSTEM: begin
        if (funct3[2] && (EN_ZIMM != 0)) begin
          fmt = FMT_ZIMM;
          imm = XLEN'(instr[19:15]);
        end
      end
      OP_REG, OP_FENCE: begin
        illegal = 1'b0;
      end
      OP_REG32: begin
        illegal = (XLEN == 32);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator behind a 2-entry skid buffer: decode at the input,
// register the result, and hold a second entry while downstream stalls.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int EN_ZIMM = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_target;

  imm_decode #(
    .XLEN    (XLEN),
    .EN_ZIMM (EN_ZIMM)
  ) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign dec_target = in_pc + dec_imm;

  logic            out_valid_reg;
  logic [XLEN-1:0] out_imm_reg;
  fmt_e            out_fmt_reg;
  logic [XLEN-1:0] out_target_reg;
  logic            out_illegal_reg;

  logic            skid_valid_reg;
  logic [XLEN-1:0] skid_imm_reg;
  fmt_e            skid_fmt_reg;
  logic [XLEN-1:0] skid_target_reg;
  logic            skid_illegal_reg;

  logic in_fire;
  logic out_free;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign in_ready = ~skid_valid_reg;
  assign in_fire  = in_valid & in_ready;
  assign out_free = ~out_valid_reg | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg    <= 1'b0;
      out_imm_reg      <= '0;
      out_fmt_reg      <= FMT_NONE;
      out_target_reg   <= '0;
      out_illegal_reg  <= 1'b0;
      skid_valid_reg   <= 1'b0;
      skid_imm_reg     <= '0;
      skid_fmt_reg     <= FMT_NONE;
      skid_target_reg  <= '0;
      skid_illegal_reg <= 1'b0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (out_free) begin
      // Skid entry is older than anything arriving now, so it drains first.
      if (skid_valid_reg) begin
        out_valid_reg   <= 1'b1;
        out_imm_reg     <= skid_imm_reg;
        out_fmt_reg     <= skid_fmt_reg;
        out_target_reg  <= skid_target_reg;
        out_illegal_reg <= skid_illegal_reg;
        skid_valid_reg  <= 1'b0;
      end else if (in_fire) begin
        out_valid_reg   <= 1'b1;
        out_imm_reg     <= dec_imm;
        out_fmt_reg     <= dec_fmt;
        out_target_reg  <= dec_target;
        out_illegal_reg <= dec_illegal;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_reg   <= 1'b1;
      skid_imm_reg     <= dec_imm;
      skid_fmt_reg     <= dec_fmt;
      skid_target_reg  <= dec_target;
      skid_illegal_reg <= dec_illegal;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_imm     = out_imm_reg;
  assign out_fmt     = out_fmt_reg;
  assign out_target  = out_target_reg;
  assign out_illegal = out_illegal_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: three configurations (RV32, RV64, RV32 without zimm)
// share one stimulus stream and are compared against a queue-based reference.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] pc;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_imm, a_tgt;
  logic [2:0]  a_fmt;
  logic        b_in_ready, b_out_valid, b_ill;
  logic [63:0] b_imm, b_tgt;
  logic [2:0]  b_fmt;
  logic        c_in_ready, c_out_valid, c_ill;
  logic [31:0] c_imm, c_tgt;
  logic [2:0]  c_fmt;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .EN_ZIMM(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_imm), .out_fmt(a_fmt), .out_target(a_tgt), .out_illegal(a_ill));

  imm_gen_pipe #(.XLEN(64), .EN_ZIMM(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_imm), .out_fmt(b_fmt), .out_target(b_tgt), .out_illegal(b_ill));

  imm_gen_pipe #(.XLEN(32), .EN_ZIMM(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_instr(in_instr), .in_pc(pc[31:0]), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_imm(c_imm), .out_fmt(c_fmt), .out_target(c_tgt), .out_illegal(c_ill));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode built from the field-placement rules with integer arithmetic.
  function automatic void ref_dec(input int xlen, input bit ez, input logic [31:0] i,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output bit ill);
    longint v;
    bit     shift;
    v     = 0;
    fmt   = 3'd0;
    ill   = 1'b0;
    shift = (i[14:12] == 3'b001) || (i[14:12] == 3'b101);
    case (i[6:0])
      7'h13, 7'h1B: begin
        if (i[6:0] == 7'h1B && xlen == 32) begin
          ill = 1'b1;
        end else if (shift) begin
          fmt = 3'd6;
          if (xlen == 64 && i[6:0] == 7'h13) v = longint'(i[25:20]);
          else begin
            v   = longint'(i[24:20]);
            ill = i[25];
          end
        end else begin
          fmt = 3'd1;
          v = longint'(i[31:20]);
          if (v >= 2048) v -= 4096;
        end
      end
      7'h03, 7'h67: begin
        fmt = 3'd1;
        v = longint'(i[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        fmt = 3'd2;
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        fmt = 3'd3;
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
            + longint'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h37, 7'h17: begin
        fmt = 3'd4;
        v = longint'(i[31:12]) * 4096;
        if (v >= 64'sd2147483648) v -= 64'sd4294967296;
      end
      7'h6F: begin
        fmt = 3'd5;
        v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
            + longint'(i[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      7'h73: begin
        if (i[14] && ez) begin
          fmt = 3'd7;
          v = longint'(i[19:15]);
        end
      end
      7'h33, 7'h0F: ill = 1'b0;
      7'h3B: ill = (xlen == 32);
      default: ill = 1'b1;
    endcase
    imm = 64'(v);
  endfunction

  task automatic chk_inst(input string tag, input int xlen, input bit ez, input ent_t e,
                          input logic [63:0] imm_o, input logic [63:0] tgt_o,
                          input logic [2:0] fmt_o, input logic ill_o);
    logic [63:0] imm, mask;
    logic [2:0]  fmt;
    bit          ill;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    ref_dec(xlen, ez, e.instr, imm, fmt, ill);
    chk({tag, "_imm"}, imm_o, imm & mask);
    chk({tag, "_tgt"}, tgt_o, (e.pc + imm) & mask);
    chk({tag, "_fmt"}, 64'(fmt_o), 64'(fmt));
    chk({tag, "_ill"}, 64'(ill_o), 64'(ill));
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    bit in_fire, out_fire;
    @(negedge clk);
    chk("a_in_ready", 64'(a_in_ready), 64'(q.size() < 2));
    chk("b_in_ready", 64'(b_in_ready), 64'(q.size() < 2));
    chk("c_in_ready", 64'(c_in_ready), 64'(q.size() < 2));
    chk("a_out_valid", 64'(a_out_valid), 64'(q.size() > 0));
    chk("b_out_valid", 64'(b_out_valid), 64'(q.size() > 0));
    chk("c_out_valid", 64'(c_out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk_inst("a", 32, 1'b1, q[0], 64'(a_imm), 64'(a_tgt), a_fmt, a_ill);
      chk_inst("b", 64, 1'b1, q[0], b_imm, b_tgt, b_fmt, b_ill);
      chk_inst("c", 32, 1'b0, q[0], 64'(c_imm), 64'(c_tgt), c_fmt, c_ill);
    end
    in_fire  = in_valid && (q.size() < 2);
    out_fire = out_ready && (q.size() > 0);
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (out_fire) begin
        xfers++;
        $display("xfer %0d instr=%h pc=%h imm32=%h imm64=%h fmt=%0d", xfers, q[0].instr,
                 q[0].pc, a_imm, b_imm, b_fmt);
        void'(q.pop_front());
      end
      if (in_fire) q.push_back('{in_instr, pc});
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] p,
                       input logic rdy);
    in_valid  = v;
    in_instr  = instr;
    pc        = p;
    out_ready = rdy;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[13];
    logic [31:0] r;
    int          k;
    ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33,
            7'h3B, 7'h0F};
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k < 13) r[6:0] = ops[k];
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 1'b1);
    #2;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_in_ready", 64'(b_in_ready), 64'd1);
    chk("rst_imm", b_imm, 64'd0);
    chk("rst_tgt", b_tgt, 64'd0);
    chk("rst_fmt", 64'(a_fmt), 64'd0);
    chk("rst_ill", 64'(a_ill), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed decode vectors
    drive(1'b1, 32'hFFF00093, 64'h100, 1'b1);
    cycle();
    chk("addi_imm", 64'(a_imm), 64'hFFFF_FFFF);
    chk("addi_fmt", 64'(a_fmt), 64'd1);
    chk("addi_tgt", 64'(a_tgt), 64'h0000_00FF);
    drive(1'b1, 32'h800000B7, 64'h0, 1'b1);
    cycle();
    chk("lui64_imm", b_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui64_fmt", 64'(b_fmt), 64'd4);
    drive(1'b1, 32'hFE000EE3, 64'h1000, 1'b1);
    cycle();
    chk("beq_imm", 64'(a_imm), 64'hFFFF_FFFC);
    chk("beq_tgt", 64'(a_tgt), 64'h0000_0FFC);
    chk("beq_fmt", 64'(a_fmt), 64'd3);
    drive(1'b1, 32'h02009093, 64'h0, 1'b1);
    cycle();
    chk("slli32_ill", 64'(a_ill), 64'd1);
    chk("slli32_fmt", 64'(a_fmt), 64'd6);
    chk("slli64_ill", 64'(b_ill), 64'd0);
    drive(1'b1, 32'h0000007F, 64'h0, 1'b1);
    cycle();
    chk("op7f_ill", 64'(a_ill), 64'd1);
    chk("op7f_fmt", 64'(a_fmt), 64'd0);
    drive(1'b1, 32'h0000F073, 64'h0, 1'b1);
    cycle();
    drive(1'b0, 32'h0, 64'h0, 1'b1);
    cycle();

    // Back-to-back with a two-cycle downstream stall
    drive(1'b1, 32'h00100013, 64'h10, 1'b1);
    cycle();
    drive(1'b1, 32'h00200013, 64'h14, 1'b0);
    cycle();
    chk("stall_in_ready", 64'(a_in_ready), 64'd0);
    drive(1'b1, 32'h00300013, 64'h18, 1'b0);
    cycle();
    drive(1'b1, 32'h00300013, 64'h18, 1'b1);
    cycle();
    cycle();
    drive(1'b0, 32'h0, 64'h0, 1'b1);
    cycle();
    cycle();

    // Flush with two entries buffered and a colliding input
    drive(1'b1, 32'h00400013, 64'h20, 1'b0);
    cycle();
    drive(1'b1, 32'h00500013, 64'h24, 1'b0);
    cycle();
    drive(1'b1, 32'h00600013, 64'h28, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_out_valid", 64'(a_out_valid), 64'd0);
    chk("flush_in_ready", 64'(a_in_ready), 64'd1);
    drive(1'b0, 32'h0, 64'h0, 1'b1);
    cycle();
    cycle();

    // Asynchronous reset while stalled with two entries held
    drive(1'b1, 32'h00700013, 64'h30, 1'b0);
    cycle();
    drive(1'b1, 32'h00800013, 64'h34, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 64'h0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(b_out_valid), 64'd0);
    chk("arst_in_ready", 64'(b_in_ready), 64'd1);
    chk("arst_imm", b_imm, 64'd0);
    q.delete();
    #1 rst_n = 1'b1;
    cycle();
    cycle();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) != 0, rand_instr(), {$urandom, $urandom}, ($urandom % 3) != 0);
      flush = (($urandom % 25) == 0);
      cycle();
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 1'b1);
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
